// File: rtl/nibble_serial_adder_if.sv
// Purpose: bundles the word request/result bus and the nibble-slice CLA bus of nibble_serial_adder.
// Latency: none, wires only.
// Backpressure: none; start is simply ignored while busy is high.
// Optional feature macro: NIBBLE_SERIAL_OVF_EN adds the signed-overflow flag V.
interface nibble_serial_adder_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    // word request / result
    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Cin;
    logic         busy;
    logic         done;
    logic [W-1:0] S;
    logic         Cout;
`ifdef NIBBLE_SERIAL_OVF_EN
    logic         V;
`endif

    // nibble slice to/from the external 4-bit CLA
    logic [3:0]   nA;
    logic [3:0]   nB;
    logic         nCin;
    logic [3:0]   nS;
    logic         nCout;

    // master: requester that also hosts the CLA
    modport master (
        output start, A, B, Cin, nS, nCout,
        input  busy, done, S, Cout, nA, nB, nCin
`ifdef NIBBLE_SERIAL_OVF_EN
        , input V
`endif
    );

    // slave: the nibble sequencer itself
    modport slave (
        input  start, A, B, Cin, nS, nCout,
        output busy, done, S, Cout, nA, nB, nCin
`ifdef NIBBLE_SERIAL_OVF_EN
        , output V
`endif
    );
endinterface

// File: rtl/nibble_serial_adder.sv
// Purpose: sequences a W=4*NIBBLES bit add through an external 4-bit CLA, one nibble per clock.
// Latency: done pulses NIBBLES edges after the start-accepting edge; a new start is taken in the done cycle.
// Backpressure: none; start while busy is dropped, not queued. Macro NIBBLE_SERIAL_OVF_EN adds output V.
module nibble_serial_adder #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    nibble_serial_adder_if.slave bus
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    logic [IW-1:0] idx;
    logic [W-1:0]  a_r;
    logic [W-1:0]  b_r;
    logic          c_r;
    logic [W-1:0]  s_r;
    logic          cout_r;
    logic          busy_r;
    logic          done_r;
`ifdef NIBBLE_SERIAL_OVF_EN
    logic          v_r;
`endif

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.S    = s_r;
    assign bus.Cout = cout_r;
`ifdef NIBBLE_SERIAL_OVF_EN
    assign bus.V    = v_r;
`endif

    // Present the current operand slice and chained carry to the CLA only while running.
    always_comb begin
        bus.nA   = 4'd0;
        bus.nB   = 4'd0;
        bus.nCin = 1'b0;
        if (state == RUN) begin
            bus.nA   = a_r[{idx, 2'b00} +: 4];
            bus.nB   = b_r[{idx, 2'b00} +: 4];
            bus.nCin = c_r;
        end
    end

    // Sequencer: latch operands, capture one CLA nibble per clock, pulse done at the end.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            idx    <= '0;
            a_r    <= '0;
            b_r    <= '0;
            c_r    <= 1'b0;
            s_r    <= '0;
            cout_r <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
`ifdef NIBBLE_SERIAL_OVF_EN
            v_r    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        a_r    <= bus.A;
                        b_r    <= bus.B;
                        c_r    <= bus.Cin;
                        idx    <= '0;
                        busy_r <= 1'b1;
                        state  <= RUN;
                    end else begin
                        state  <= IDLE;
                    end
                end
                RUN: begin
                    s_r[{idx, 2'b00} +: 4] <= bus.nS;
                    c_r                    <= bus.nCout;
                    if (idx == LAST) begin
                        cout_r <= bus.nCout;
`ifdef NIBBLE_SERIAL_OVF_EN
                        // Same-sign operands whose top sum bit flips sign -> signed overflow.
                        v_r    <= (a_r[W-1] == b_r[W-1]) && (bus.nS[3] != a_r[W-1]);
`endif
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        state  <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Purpose: self-checking bench for nibble_serial_adder with a 4-bit CLA stand-in and a word-level reference model.
// Latency: expects done NIBBLES edges after the start-accepting edge.
// Backpressure: exercises start while busy (must be dropped) and start in the done cycle (must be taken).
module tb_nibble_serial_adder;
    localparam int N = 4;
    localparam int W = 4 * N;

    logic clk = 1'b0;
    logic rst = 1'b0;

    nibble_serial_adder_if #(.NIBBLES(N)) ifc ();

    nibble_serial_adder #(.NIBBLES(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    always #5 clk = ~clk;

    // 4-bit carry-lookahead adder stand-in
    assign {ifc.nCout, ifc.nS} = 5'(ifc.nA) + 5'(ifc.nB) + 5'(ifc.nCin);

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- word-level reference model ----------------
    int           cnt;        // RUN cycles left; 0 means not busy
    logic [W-1:0] m_a, m_b;
    logic         m_cin;
    logic         exp_done, exp_cout, exp_v;
    logic [W-1:0] exp_s;
    logic [W:0]   sum;

    // Track accepted adds and the word result they must produce.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt = 0; m_a = '0; m_b = '0; m_cin = 1'b0;
            exp_done = 1'b0; exp_cout = 1'b0; exp_v = 1'b0; exp_s = '0;
        end else begin
            exp_done = 1'b0;
            if (cnt > 0) begin
                cnt = cnt - 1;
                if (cnt == 0) begin
                    sum      = {1'b0, m_a} + {1'b0, m_b} + (W+1)'(m_cin);
                    exp_s    = sum[W-1:0];
                    exp_cout = sum[W];
                    exp_v    = (m_a[W-1] == m_b[W-1]) && (sum[W-1] != m_a[W-1]);
                    exp_done = 1'b1;
                end
            end else if (ifc.start) begin
                cnt = N; m_a = ifc.A; m_b = ifc.B; m_cin = ifc.Cin;
            end
        end
    end

    // Compare DUT outputs against the model every cycle, mid-cycle.
    logic cmp_en = 1'b0;
    always @(negedge clk) begin
        int i;
        logic [63:0] msk, carry;
        if (cmp_en) begin
            check("busy", 64'(ifc.busy), 64'(cnt > 0));
            check("done", 64'(ifc.done), 64'(exp_done));
            check("Cout", 64'(ifc.Cout), 64'(exp_cout));
`ifdef NIBBLE_SERIAL_OVF_EN
            check("V", 64'(ifc.V), 64'(exp_v));
`endif
            if (cnt == 0) begin
                check("S_held", 64'(ifc.S), 64'(exp_s));
                check("nA_idle", 64'(ifc.nA), 64'd0);
                check("nB_idle", 64'(ifc.nB), 64'd0);
                check("nCin_idle", 64'(ifc.nCin), 64'd0);
            end else begin
                i     = N - cnt;
                msk   = (64'd1 << (4 * i)) - 64'd1;
                carry = ((64'(m_a) & msk) + (64'(m_b) & msk) + 64'(m_cin)) >> (4 * i);
                check("nA_run", 64'(ifc.nA), (64'(m_a) >> (4 * i)) & 64'hF);
                check("nB_run", 64'(ifc.nB), (64'(m_b) >> (4 * i)) & 64'hF);
                check("nCin_run", 64'(ifc.nCin), carry & 64'd1);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    logic nc_log [N];

    // Present one start (caller is just after a rising edge) and wait, bounded, for done.
    task automatic do_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, output int edges);
        ifc.start = 1'b1; ifc.A = a; ifc.B = b; ifc.Cin = cin;
        @(posedge clk); #1;
        ifc.start = 1'b0;
        edges = 0;
        while (ifc.done !== 1'b1 && edges < 4 * N + 8) begin
            if (edges < N) nc_log[edges] = ifc.nCin;
            @(posedge clk); #1;
            edges++;
        end
        check("done_seen", 64'(ifc.done), 64'd1);
    endtask

    function automatic logic [W-1:0] rnd_op();
        logic [W-1:0] v;
        case ($urandom_range(0, 7))
            0: v = '0;
            1: v = '1;
            2: v = {1'b1, {(W-1){1'b0}}};
            3: v = {1'b0, {(W-1){1'b1}}};
            default: v = W'({$urandom, $urandom});
        endcase
        return v;
    endfunction

    initial begin
        int e;
        int dcount;
        ifc.start = 1'b0; ifc.A = '0; ifc.B = '0; ifc.Cin = 1'b0;
        #1 rst = 1'b1;
        #1 cmp_en = 1'b1;
        check("rst_busy", 64'(ifc.busy), 64'd0);
        check("rst_done", 64'(ifc.done), 64'd0);
        check("rst_S", 64'(ifc.S), 64'd0);
        check("rst_Cout", 64'(ifc.Cout), 64'd0);
        #11 rst = 1'b0;
        @(posedge clk); #1;

        // small add, latency
        do_add(16'h000A, 16'h0005, 1'b0, e);
        check("lat_a", 64'(e), 64'(N));
        check("sum_a_S", 64'(ifc.S), 64'h000F);
        check("sum_a_Cout", 64'(ifc.Cout), 64'd0);
        @(posedge clk); #1;
        check("done_pulse_once", 64'(ifc.done), 64'd0);
        check("S_hold_idle", 64'(ifc.S), 64'h000F);
        @(posedge clk); #1;

        // carry ripples through every slice
        do_add(16'hFFFF, 16'h0001, 1'b0, e);
        check("ripple_S", 64'(ifc.S), 64'h0000);
        check("ripple_Cout", 64'(ifc.Cout), 64'd1);
        check("ripple_nCin0", 64'(nc_log[0]), 64'd0);
        for (int k = 1; k < N; k++) check("ripple_nCin", 64'(nc_log[k]), 64'd1);
        @(posedge clk); #1;

        // back-to-back: second start issued in the done cycle
        do_add(16'h1234, 16'h4321, 1'b1, e);
        check("b2b_first_S", 64'(ifc.S), 64'h5556);
        check("b2b_first_Cout", 64'(ifc.Cout), 64'd0);
        do_add(16'h0002, 16'h0004, 1'b0, e);
        check("b2b_lat", 64'(e), 64'(N));
        check("b2b_second_S", 64'(ifc.S), 64'h0006);
        @(posedge clk); #1;

        // start during RUN is dropped
        ifc.start = 1'b1; ifc.A = 16'h0101; ifc.B = 16'h0202; ifc.Cin = 1'b0;
        @(posedge clk); #1; ifc.start = 1'b0;
        @(posedge clk); #1;
        ifc.start = 1'b1; ifc.A = 16'hFFFF; ifc.B = 16'hFFFF; ifc.Cin = 1'b1;
        @(posedge clk); #1; ifc.start = 1'b0;
        dcount = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (ifc.done) begin
                dcount++;
                check("ignore_S", 64'(ifc.S), 64'h0303);
            end
        end
        check("ignore_done_count", 64'(dcount), 64'd1);

        // reset in the third RUN cycle
        ifc.start = 1'b1; ifc.A = 16'h0F0F; ifc.B = 16'h1111; ifc.Cin = 1'b0;
        @(posedge clk); #1; ifc.start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2 rst = 1'b1;
        #1;
        check("abort_busy", 64'(ifc.busy), 64'd0);
        check("abort_done", 64'(ifc.done), 64'd0);
        check("abort_S", 64'(ifc.S), 64'd0);
        check("abort_Cout", 64'(ifc.Cout), 64'd0);
        #3 rst = 1'b0;
        dcount = 0;
        for (int k = 0; k < N + 4; k++) begin
            @(posedge clk); #1;
            if (ifc.done) dcount++;
        end
        check("abort_no_done", 64'(dcount), 64'd0);

`ifdef NIBBLE_SERIAL_OVF_EN
        do_add(16'h7FFF, 16'h0001, 1'b0, e);
        check("ovf1_S", 64'(ifc.S), 64'h8000);
        check("ovf1_V", 64'(ifc.V), 64'd1);
        check("ovf1_Cout", 64'(ifc.Cout), 64'd0);
        do_add(16'h8000, 16'hFFFF, 1'b0, e);
        check("ovf2_S", 64'(ifc.S), 64'h7FFF);
        check("ovf2_V", 64'(ifc.V), 64'd1);
        check("ovf2_Cout", 64'(ifc.Cout), 64'd1);
        @(posedge clk); #1;
`endif

        // random traffic: starts at arbitrary times, including during RUN and in DONE
        for (int k = 0; k < 2000; k++) begin
            ifc.start = ($urandom_range(0, 3) == 0);
            ifc.A     = rnd_op();
            ifc.B     = rnd_op();
            ifc.Cin   = 1'($urandom);
            @(posedge clk); #1;
        end
        ifc.start = 1'b0;
        for (int k = 0; k < N + 3; k++) begin
            @(posedge clk); #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
